// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the pipeline register stages.
// Occupancy states and write-back control bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int WB_REGWRITE = 3;
    localparam int WB_MEMTOREG = 2;
    localparam int WB_PCTOREG  = 1;
    localparam int WB_HALT     = 0;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One payload slot of the skid stage: ctrl, data, dst and pc.
// Clear wins over load so an empty slot always reads as a nop.
module pipe_entry #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32,
    parameter int DST_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DST_W-1:0]  dst_i,
    input  logic [15:0]       pc_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [DST_W-1:0]  dst_o,
    output logic [15:0]       pc_o
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic [DST_W-1:0]  dst_q;
    logic [15:0]       pc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            ctrl_q <= '0;
            data_q <= '0;
            dst_q  <= '0;
            pc_q   <= '0;
        end else if (load_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
            dst_q  <= dst_i;
            pc_q   <= pc_i;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;
    assign dst_o  = dst_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with 2-entry skid buffer, flush and sticky halt.
// in_ready comes only from registers, so stalls never form a comb path.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_DATA = 2,
    parameter int CTRL_W   = 4,
    parameter int DST_W    = 4,
    parameter int HALT_BIT = WB_HALT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [DST_W-1:0]           in_dst,
    input  logic [15:0]                in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [DST_W-1:0]           out_dst,
    output logic [15:0]                out_pc,
    output logic                       halted,
    output logic [1:0]                 occupancy
);

    localparam int DW = NUM_DATA * DATA_W;

    state_e state_q, state_d;
    logic   halted_q, halted_d;
    logic   accept, retire;
    logic   h_load, h_clr, h_from_s, s_load, s_clr;

    logic [CTRL_W-1:0] h_ctrl, s_ctrl, hd_ctrl;
    logic [DW-1:0]     h_data, s_data, hd_data;
    logic [DST_W-1:0]  h_dst, s_dst, hd_dst;
    logic [15:0]       h_pc, s_pc, hd_pc;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL) && !halted_q;
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        h_load   = 1'b0;
        h_clr    = 1'b0;
        h_from_s = 1'b0;
        s_load   = 1'b0;
        s_clr    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            h_clr   = 1'b1;
            s_clr   = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        h_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        h_load = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        s_load  = 1'b1;
                    end else if (retire) begin
                        state_d = EMPTY;
                        h_clr   = 1'b1;
                    end
                end
                FULL: begin
                    if (retire) begin
                        state_d  = ONE;
                        h_load   = 1'b1;
                        h_from_s = 1'b1;
                        s_clr    = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    h_clr   = 1'b1;
                    s_clr   = 1'b1;
                end
            endcase
        end
    end

    // A retire during flush still counts, so halt can latch then too.
    assign halted_d = halted_q || (retire && h_ctrl[HALT_BIT]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign hd_ctrl = h_from_s ? s_ctrl : in_ctrl;
    assign hd_data = h_from_s ? s_data : in_data;
    assign hd_dst  = h_from_s ? s_dst  : in_dst;
    assign hd_pc   = h_from_s ? s_pc   : in_pc;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DW), .DST_W(DST_W)) u_head (
        .clk    (clk),
        .rst    (rst),
        .load_i (h_load),
        .clr_i  (h_clr),
        .ctrl_i (hd_ctrl),
        .data_i (hd_data),
        .dst_i  (hd_dst),
        .pc_i   (hd_pc),
        .ctrl_o (h_ctrl),
        .data_o (h_data),
        .dst_o  (h_dst),
        .pc_o   (h_pc)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DW), .DST_W(DST_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (s_load),
        .clr_i  (s_clr),
        .ctrl_i (in_ctrl),
        .data_i (in_data),
        .dst_i  (in_dst),
        .pc_i   (in_pc),
        .ctrl_o (s_ctrl),
        .data_o (s_data),
        .dst_o  (s_dst),
        .pc_o   (s_pc)
    );

    assign out_ctrl  = out_valid ? h_ctrl : '0;
    assign out_data  = out_valid ? h_data : '0;
    assign out_dst   = out_valid ? h_dst  : '0;
    assign out_pc    = out_valid ? h_pc   : '0;
    assign halted    = halted_q;
    assign occupancy = state_q;

endmodule
